lsu_mem_port: RTL

- Load/store unit that consumes the decoder's `mem_opcode` together with the ALU-computed address and the rs2 data.
- Runs one request/acknowledge transaction on the data-memory bus, with byte-lane steering.
- Returns sign- or zero-extended load data and a completion pulse to the writeback stage.
- Sits between execute and data memory; it is the responder end of the decoder's memory-op interface.

---
 rtl/lsu_mem_port.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit on the data-memory side of execute.
//
// Takes a memory op from the decoder (mem_opcode, mem_unsigned), the ALU address and the rs2
// store data. It runs one request/acknowledge transaction on the data bus with byte-lane
// steering, then pulses done, with sign/zero-extended load data for loads.
//
// Ports:
//   i_clk, i_rst         rising-edge clock, synchronous active-high reset
//   i_start              launch an op (sampled only when idle)
//   i_mem_opcode[2:0]    [2] load/store, [1:0] byte/half/word/no-access
//   i_mem_unsigned       zero-extend load data
//   i_addr, i_wdata      byte address, store data
//   o_busy               not idle
//   o_done               one-cycle completion pulse
//   o_rdata              extended load data, held until the next completed load
//   o_rdata_valid        pulses with done for completed loads
//   o_misalign           pulses with done for a rejected misaligned op
//   o_err                pulses with done on bus timeout
//   o_bus_*              data-bus request side (req, we, word addr, byte enables, wdata)
//   i_bus_ack            bus completion (only honoured while requesting)
//   i_bus_rdata          read word, valid with i_bus_ack
//
// Optional feature macro: LSU_BUS_TIMEOUT_EN. When it is defined, a request that waits
// TIMEOUT_CYCLES cycles without an ack ends with err. Otherwise the unit waits indefinitely
// and o_err stays 0.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_mem_opcode,
    input  logic        i_mem_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_misalign,
    output logic        o_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    // A zero timeout would expire before the bus could ever answer.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("lsu_mem_port: TIMEOUT_CYCLES must be at least 1");
    end

    state_e      r_state, w_state_next;
    logic        r_is_load, w_is_load_next;
    logic [1:0]  r_size, w_size_next;
    logic        r_unsigned, w_unsigned_next;
    logic [1:0]  r_lane, w_lane_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic [31:0] r_rdata, w_rdata_next;
    logic        r_rdata_valid, w_rdata_valid_next;
    logic        r_misalign, w_misalign_next;
    logic        r_err, w_err_next;
    logic        r_bus_req, w_bus_req_next;
    logic        r_bus_we, w_bus_we_next;
    logic [31:0] r_bus_addr, w_bus_addr_next;
    logic [3:0]  r_bus_be, w_bus_be_next;
    logic [31:0] r_bus_wdata, w_bus_wdata_next;

    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_load_shift;
    logic [31:0] w_load_ext;
    logic        w_tmo_expired;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int unsigned CntWidth =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntWidth-1:0] r_tmo_cnt;

    assign w_tmo_expired = (r_tmo_cnt == CntWidth'(TIMEOUT_CYCLES));

    // Held at zero outside REQ, so every request starts counting from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != StReq) begin
            r_tmo_cnt <= '0;
        end else if (!i_bus_ack && !w_tmo_expired) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_tmo_expired = 1'b0;
`endif

    // Request-side decode straight from the launch inputs.
    always_comb begin
        w_misaligned = ((i_mem_opcode[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_mem_opcode[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        unique case (i_mem_opcode[1:0])
            2'b00: begin
                w_be        = 4'b0001 << i_addr[1:0];
                w_wdata_rep = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << i_addr[1:0];
                w_wdata_rep = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = i_wdata;
            end
        endcase
    end

    // Halves are 2-byte aligned, so the byte-lane shift also right-aligns them.
    always_comb begin
        w_load_shift = i_bus_rdata >> {r_lane, 3'b000};
        unique case (r_size)
            2'b00:   w_load_ext = {{24{~r_unsigned & w_load_shift[7]}}, w_load_shift[7:0]};
            2'b01:   w_load_ext = {{16{~r_unsigned & w_load_shift[15]}}, w_load_shift[15:0]};
            default: w_load_ext = i_bus_rdata;
        endcase
    end

    always_comb begin
        w_state_next       = r_state;
        w_is_load_next     = r_is_load;
        w_size_next        = r_size;
        w_unsigned_next    = r_unsigned;
        w_lane_next        = r_lane;
        w_done_next        = 1'b0;
        w_rdata_next       = r_rdata;
        w_rdata_valid_next = 1'b0;
        w_misalign_next    = 1'b0;
        w_err_next         = 1'b0;
        w_bus_req_next     = r_bus_req;
        w_bus_we_next      = r_bus_we;
        w_bus_addr_next    = r_bus_addr;
        w_bus_be_next      = r_bus_be;
        w_bus_wdata_next   = r_bus_wdata;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (i_mem_opcode[1:0] == 2'b11) begin
                        w_state_next = StDone;
                        w_done_next  = 1'b1;
                    end else if (w_misaligned) begin
                        w_state_next    = StDone;
                        w_done_next     = 1'b1;
                        w_misalign_next = 1'b1;
                    end else begin
                        w_state_next     = StReq;
                        w_is_load_next   = i_mem_opcode[2];
                        w_size_next      = i_mem_opcode[1:0];
                        w_unsigned_next  = i_mem_unsigned;
                        w_lane_next      = i_addr[1:0];
                        w_bus_req_next   = 1'b1;
                        w_bus_we_next    = ~i_mem_opcode[2];
                        w_bus_addr_next  = {i_addr[31:2], 2'b00};
                        w_bus_be_next    = w_be;
                        w_bus_wdata_next = w_wdata_rep;
                    end
                end
            end
            StReq: begin
                // An ack in the expiry cycle still completes normally.
                if (i_bus_ack) begin
                    w_state_next   = StDone;
                    w_done_next    = 1'b1;
                    w_bus_req_next = 1'b0;
                    if (r_is_load) begin
                        w_rdata_next       = w_load_ext;
                        w_rdata_valid_next = 1'b1;
                    end
                end else if (w_tmo_expired) begin
                    w_state_next   = StDone;
                    w_done_next    = 1'b1;
                    w_err_next     = 1'b1;
                    w_bus_req_next = 1'b0;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase

        w_busy_next = (w_state_next != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_is_load     <= 1'b0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_lane        <= 2'b00;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_err         <= 1'b0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_be      <= '0;
            r_bus_wdata   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_is_load     <= w_is_load_next;
            r_size        <= w_size_next;
            r_unsigned    <= w_unsigned_next;
            r_lane        <= w_lane_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_rdata       <= w_rdata_next;
            r_rdata_valid <= w_rdata_valid_next;
            r_misalign    <= w_misalign_next;
            r_err         <= w_err_next;
            r_bus_req     <= w_bus_req_next;
            r_bus_we      <= w_bus_we_next;
            r_bus_addr    <= w_bus_addr_next;
            r_bus_be      <= w_bus_be_next;
            r_bus_wdata   <= w_bus_wdata_next;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_misalign    = r_misalign;
    assign o_err         = r_err;
    assign o_bus_req     = r_bus_req;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_be      = r_bus_be;
    assign o_bus_wdata   = r_bus_wdata;

endmodule
